// File: rtl/sample_pingpong_if.sv
// Sample ping-pong bus: codec/FFT-control side (master) to bank scheduler (slave).
// Optional feature macro: SAMPLE_PP_DROP_CNT_EN adds the dropped_count field.
interface sample_pingpong_if #(
  parameter int unsigned DATA_W = 16
);

  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              write_even;
  logic              write_odd;
  logic              read;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full_even;
  logic              full_odd;
  logic              empty_even;
  logic              empty_odd;
  logic              overflow;
`ifdef SAMPLE_PP_DROP_CNT_EN
  logic [15:0]       dropped_count;
`endif

  // Codec and FFT control drive samples, enables and read strobes
  modport master (
    output sample_in, sample_valid, write_even, write_odd, read,
`ifdef SAMPLE_PP_DROP_CNT_EN
    input  dropped_count,
`endif
    input  rd_data, rd_valid, full_even, full_odd, empty_even, empty_odd, overflow
  );

  // Scheduler consumes samples and returns drained data and status
  modport slave (
    input  sample_in, sample_valid, write_even, write_odd, read,
`ifdef SAMPLE_PP_DROP_CNT_EN
    output dropped_count,
`endif
    output rd_data, rd_valid, full_even, full_odd, empty_even, empty_odd, overflow
  );

endinterface

// File: rtl/sample_pingpong_ctrl.sv
// Even/odd sample bank scheduler feeding the FFT loader.
// Deals samples alternately into two banks, flags a full frame, then replays
// it in original order on read strobes and re-arms for the next frame.
// Optional feature macro: SAMPLE_PP_DROP_CNT_EN adds a saturating drop counter.
module sample_pingpong_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  sample_pingpong_if.slave     bus
);

  localparam int unsigned BANK_D  = DEPTH / 2;
  localparam int unsigned BANK_AW = ADDR_W - 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_FULL  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0]  rd_data_q;
  logic               rd_valid_q;
  logic               full_q;
  logic               empty_even_q;
  logic               empty_odd_q;
  logic               overflow_q;

  logic [DATA_W-1:0]  bank_even [BANK_D];
  logic [DATA_W-1:0]  bank_odd  [BANK_D];

  logic [BANK_AW-1:0] wr_addr;
  logic [BANK_AW-1:0] rd_addr;
  logic               wr_odd;
  logic               wr_en;
  logic               wr_last;
  logic               rd_last;
  logic               accept;
  logic               drop;
  logic               issue;
  logic [DATA_W-1:0]  rd_word;

  assign wr_addr = wr_ptr[ADDR_W-1:1];
  assign rd_addr = rd_ptr[ADDR_W-1:1];
  assign wr_odd  = wr_ptr[0];
  assign wr_en   = wr_odd ? bus.write_odd : bus.write_even;
  assign wr_last = (wr_ptr == LAST_IDX);
  assign rd_last = (rd_ptr == LAST_IDX);
  assign rd_word = rd_ptr[0] ? bank_odd[rd_addr] : bank_even[rd_addr];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FILL;
    else       state <= state_nx;
  end

  // Next state plus accept/drop/issue decisions
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    drop     = 1'b0;
    issue    = 1'b0;
    unique case (state)
      S_FILL: begin
        if (bus.sample_valid) begin
          if (wr_en) begin
            accept = 1'b1;
            if (wr_last) state_nx = S_FULL;
          end else begin
            drop = 1'b1;
          end
        end
      end
      S_FULL: begin
        drop = bus.sample_valid;
        if (bus.read) begin
          issue    = 1'b1;
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drop = bus.sample_valid;
        if (bus.read) begin
          issue = 1'b1;
          if (rd_last) state_nx = S_FILL;
        end
      end
      default: state_nx = S_FILL;
    endcase
  end

  // Bank storage; contents need no reset since flags gate their use
  always_ff @(posedge clk) begin
    if (accept) begin
      if (wr_odd) bank_odd[wr_addr]  <= bus.sample_in;
      else        bank_even[wr_addr] <= bus.sample_in;
    end
  end

  // Pointers, status flags and registered read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      full_q       <= 1'b0;
      empty_even_q <= 1'b1;
      empty_odd_q  <= 1'b1;
      overflow_q   <= 1'b0;
    end else begin
      rd_valid_q <= issue;
      if (drop) overflow_q <= 1'b1;
      if (accept) begin
        if (wr_odd) empty_odd_q  <= 1'b0;
        else        empty_even_q <= 1'b0;
        // Pointer parks at the last index until the frame is drained
        if (wr_last) full_q <= 1'b1;
        else         wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (issue) begin
        rd_data_q <= rd_word;
        if (rd_last) begin
          rd_ptr       <= '0;
          wr_ptr       <= '0;
          full_q       <= 1'b0;
          empty_even_q <= 1'b1;
          empty_odd_q  <= 1'b1;
        end else begin
          rd_ptr <= rd_ptr + ADDR_W'(1);
        end
      end
    end
  end

`ifdef SAMPLE_PP_DROP_CNT_EN
  logic [15:0] drop_cnt;

  // Saturating count of dropped samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end

  assign bus.dropped_count = drop_cnt;
`endif

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.full_even  = full_q;
  assign bus.full_odd   = full_q;
  assign bus.empty_even = empty_even_q;
  assign bus.empty_odd  = empty_odd_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_sample_pingpong_ctrl.sv
// Scoreboard bench for sample_pingpong_ctrl.
// Define SAMPLE_PP_DROP_CNT_EN to also check the drop counter.
module tb_sample_pingpong_ctrl;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 512;
  localparam int unsigned ADDR_W = 9;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sample_pingpong_if #(.DATA_W(DATA_W)) bus ();

  sample_pingpong_ctrl #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] frame_q [$];
  logic [DATA_W-1:0] exp_q   [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drained samples are compared in arrival order against the scoreboard
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) check("rd_unexpected", 32'(1), 32'(0));
      else                   check("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic idle();
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.write_even   = 1'b1;
    bus.write_odd    = 1'b1;
    bus.read         = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_flags(input string tag);
    check({tag, "_full_even"},  32'(bus.full_even),  32'(0));
    check({tag, "_full_odd"},   32'(bus.full_odd),   32'(0));
    check({tag, "_empty_even"}, 32'(bus.empty_even), 32'(1));
    check({tag, "_empty_odd"},  32'(bus.empty_odd),  32'(1));
    check({tag, "_overflow"},   32'(bus.overflow),   32'(0));
    check({tag, "_rd_valid"},   32'(bus.rd_valid),   32'(0));
    check({tag, "_rd_data"},    32'(bus.rd_data),    32'(0));
`ifdef SAMPLE_PP_DROP_CNT_EN
    check({tag, "_drop_cnt"},   32'(bus.dropped_count), 32'(0));
`endif
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    frame_q.delete();
    exp_q.delete();
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic write_sample(input logic [DATA_W-1:0] data, input logic we,
                              input logic wo, input logic acc);
    bus.sample_in    = data;
    bus.sample_valid = 1'b1;
    bus.write_even   = we;
    bus.write_odd    = wo;
    if (acc) frame_q.push_back(data);
    step();
    idle();
  endtask

  // Full frame of base+i; hole>=0 inserts a rejected odd-bank write before that index
  task automatic write_frame(input int base, input int hole);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (i == hole) begin
        write_sample(16'hDEAD, 1'b1, 1'b0, 1'b0);
        check("hole_overflow",  32'(bus.overflow),  32'(1));
        check("hole_empty_odd", 32'(bus.empty_odd), 32'(1));
      end
      write_sample(DATA_W'(base + i), 1'b1, 1'b1, 1'b1);
      if (i == 0)              check("first_empty_even", 32'(bus.empty_even), 32'(0));
      if (i == int'(DEPTH) - 2) check("full_early",      32'(bus.full_even),  32'(0));
    end
    check("full_even",  32'(bus.full_even),  32'(1));
    check("full_odd",   32'(bus.full_odd),   32'(1));
    check("empty_even", 32'(bus.empty_even), 32'(0));
    check("empty_odd",  32'(bus.empty_odd),  32'(0));
  endtask

  // Drain one frame; optional 3-cycle pause after pause_at and a colliding sample at drop_at
  task automatic drain_frame(input int pause_at, input int drop_at);
    for (int i = 0; i < int'(DEPTH); i++) begin
      bus.read = 1'b1;
      if (frame_q.size() != 0) exp_q.push_back(frame_q.pop_front());
      if (i == drop_at) begin
        bus.sample_valid = 1'b1;
        bus.sample_in    = 16'hBEEF;
      end
      step();
      bus.sample_valid = 1'b0;
      check("rd_valid_lat", 32'(bus.rd_valid), 32'(1));
      if (i == pause_at) begin
        bus.read = 1'b0;
        repeat (3) begin
          step();
          check("rd_valid_pause", 32'(bus.rd_valid), 32'(0));
        end
      end
    end
    bus.read = 1'b0;
    check("drained_full_even",  32'(bus.full_even),  32'(0));
    check("drained_full_odd",   32'(bus.full_odd),   32'(0));
    check("drained_empty_even", 32'(bus.empty_even), 32'(1));
    check("drained_empty_odd",  32'(bus.empty_odd),  32'(1));
    step();
    check("drain_extra_valid", 32'(bus.rd_valid), 32'(0));
    check("scoreboard_left",   32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    reset = 1'b1;
    idle();
    do_reset();
    check_reset_flags("reset");

    // Read strobes while filling are ignored
    bus.read = 1'b1;
    repeat (3) begin
      step();
      check("fill_read_ignored", 32'(bus.rd_valid), 32'(0));
    end
    bus.read = 1'b0;

    // Fill a frame of 0..511
    write_frame(0, -1);
    check("fill_overflow", 32'(bus.overflow), 32'(0));

    // Sample while full is dropped
    write_sample(16'h7777, 1'b1, 1'b1, 1'b0);
    check("full_drop_overflow", 32'(bus.overflow), 32'(1));
`ifdef SAMPLE_PP_DROP_CNT_EN
    check("full_drop_cnt", 32'(bus.dropped_count), 32'(1));
`endif

    // Straight drain, with a sample colliding with a read mid-drain
    drain_frame(-1, 5);
    check("drain_drop_overflow", 32'(bus.overflow), 32'(1));
`ifdef SAMPLE_PP_DROP_CNT_EN
    check("drain_drop_cnt", 32'(bus.dropped_count), 32'(2));
`endif

    // Second frame drained with a pause after index 99
    write_frame(16'h1000, -1);
    drain_frame(99, -1);

    // Rejected odd write at index 1 keeps the pointer in place
    do_reset();
    check("hole_pre_overflow", 32'(bus.overflow), 32'(0));
    write_frame(16'h2000, 1);
    drain_frame(-1, -1);
`ifdef SAMPLE_PP_DROP_CNT_EN
    check("hole_drop_cnt", 32'(bus.dropped_count), 32'(1));
`endif

    // Asynchronous reset part way through a frame
    for (int i = 0; i < 100; i++) write_sample(DATA_W'(16'h3000 + i), 1'b1, 1'b1, 1'b0);
    check("partial_empty_even", 32'(bus.empty_even), 32'(0));
    #2;
    reset = 1'b1;
    #1;
    check_reset_flags("async_reset");
    frame_q.delete();
    exp_q.delete();
    step();
    reset = 1'b0;
    step();
    write_frame(16'h4000, -1);
    drain_frame(-1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
